// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Brief    : Shared state encoding and legal bit-period constants for uart_rx.
// Revision : 1.0
// ============================================================================
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int unsigned c_PRESC_8  = 8;
    localparam int unsigned c_PRESC_16 = 16;
    localparam int unsigned c_PRESC_32 = 32;

    function automatic logic presc_is_legal(input logic [31:0] presc);
        return (presc == c_PRESC_8) || (presc == c_PRESC_16) || (presc == c_PRESC_32);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Brief    : Captures the line at the three mid-bit edges and majority-votes.
// Revision : 1.0
// ============================================================================
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_rx,
    input  logic [PRESC_W-1:0] i_presc,
    input  logic [PRESC_W-1:0] i_edge_cnt,
    output logic               o_bit
);

    logic [PRESC_W-1:0] w_mid;
    logic [2:0]         r_taps;

    assign w_mid = i_presc >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_taps <= 3'b111;
        end else begin
            if (i_edge_cnt == w_mid - PRESC_W'(1)) r_taps[0] <= i_rx;
            if (i_edge_cnt == w_mid)               r_taps[1] <= i_rx;
            if (i_edge_cnt == w_mid + PRESC_W'(1)) r_taps[2] <= i_rx;
        end
    end

    assign o_bit = (r_taps[0] & r_taps[1]) | (r_taps[0] & r_taps[2]) | (r_taps[1] & r_taps[2]);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver with optional parity and error pulses.
// Revision : 1.0
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic [DATA_W-1:0]  P_DATA,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err,
    output logic               busy
);

    localparam int c_BIT_W = $clog2(DATA_W + 3);

    rx_state_t          r_state;
    rx_state_t          w_state_nxt;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_edge_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic               r_par_en;
    logic               r_par_typ;
    logic               r_par_fail;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_p_data;
    logic               r_data_valid;
    logic               r_par_err;
    logic               r_stp_err;

    logic               w_last_edge;
    logic               w_bit;
    logic               w_par_exp;
    logic               w_frame_start;
    logic               w_shift_en;
    logic               w_par_fail;
    logic               w_load;
    logic               w_dv_nxt;
    logic               w_pe_nxt;
    logic               w_se_nxt;

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk        (CLK),
        .rst        (RST),
        .i_rx       (RX_IN),
        .i_presc    (r_presc),
        .i_edge_cnt (r_edge_cnt),
        .o_bit      (w_bit)
    );

    assign w_last_edge = (r_state != ST_IDLE) && (r_edge_cnt == r_presc - PRESC_W'(1));
    assign w_par_exp   = (^r_shift) ^ r_par_typ;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_shift_en    = 1'b0;
        w_par_fail    = 1'b0;
        w_load        = 1'b0;
        w_dv_nxt      = 1'b0;
        w_pe_nxt      = 1'b0;
        w_se_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!RX_IN) begin
                    w_state_nxt   = ST_START;
                    w_frame_start = 1'b1;
                end
            end
            ST_START: begin
                // A start bit that votes high was line noise: drop it silently.
                if (w_last_edge) w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_last_edge) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_BIT_W'(DATA_W)) begin
                        w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_last_edge) begin
                    w_state_nxt = ST_STOP;
                    if (w_bit != w_par_exp) begin
                        w_par_fail = 1'b1;
                        w_pe_nxt   = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_last_edge) begin
                    if (!w_bit) begin
                        w_se_nxt = 1'b1;
                    end else if (!r_par_fail) begin
                        w_load   = 1'b1;
                        w_dv_nxt = 1'b1;
                    end
                    // A low line here is treated as the next frame's start edge.
                    if (!RX_IN) begin
                        w_state_nxt   = ST_START;
                        w_frame_start = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The detection cycle itself is edge 0, so the counter restarts at 1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_frame_start) begin
            r_edge_cnt <= PRESC_W'(1);
            r_bit_cnt  <= '0;
        end else if (r_state == ST_IDLE) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_last_edge) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + c_BIT_W'(1);
        end else begin
            r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
        end
    end

    // Unsupported bit periods fall back to 8 so a frame always terminates.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_presc    <= PRESC_W'(c_PRESC_8);
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_fail <= 1'b0;
            r_shift    <= '0;
        end else begin
            if (w_frame_start) begin
                r_presc    <= presc_is_legal(32'(Prescale)) ? Prescale : PRESC_W'(c_PRESC_8);
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_par_fail <= 1'b0;
            end else if (w_par_fail) begin
                r_par_fail <= 1'b1;
            end
            if (w_shift_en) r_shift <= {w_bit, r_shift[DATA_W-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            if (w_load) r_p_data <= r_shift;
            r_data_valid <= w_dv_nxt;
            r_par_err    <= w_pe_nxt;
            r_stp_err    <= w_se_nxt;
        end
    end

    assign P_DATA     = r_p_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx (vector table, corner cases, random frames).
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int DATA_W  = 8;
    localparam int PRESC_W = 6;
    localparam int K_DV = 0;
    localparam int K_PE = 1;
    localparam int K_SE = 2;

    typedef struct {
        int         presc;
        bit         par_en;
        bit         par_typ;
        logic [7:0] data;
        bit         flip;
        bit         stop;
        int         gap;
    } frame_t;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        frame_t     f;
        int         exp_kind;
        int         exp_cyc;
        logic [7:0] exp_pdata;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               rx_in;
    logic [PRESC_W-1:0] prescale;
    logic               par_en;
    logic               par_typ;
    logic [DATA_W-1:0]  p_data;
    logic               data_valid;
    logic               par_err;
    logic               stp_err;
    logic               busy;

    int         n_checks = 0;
    int         n_errors = 0;
    frame_t     fq[$];
    ev_t        obs_q[$];
    ev_t        exp_q[$];
    int         start_of[$];
    bit         line_q[$];
    logic [7:0] model_pdata = 8'h00;
    vec_t       vt[6];

    uart_rx #(
        .DATA_W  (DATA_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .RX_IN      (rx_in),
        .Prescale   (prescale),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pick_presc();
        case ($urandom_range(0, 2))
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    task automatic push_level(input bit v, input int cnt);
        for (int j = 0; j < cnt; j++) line_q.push_back(v);
    endtask

    // Serialise the queued frames into per-cycle line levels, predict the
    // output events from frame timing alone, then play the line and log pulses.
    task automatic play();
        int s;
        int n;
        int p;
        int fi;
        int total;
        bit pbit;
        line_q.delete();
        start_of.delete();
        exp_q.delete();
        obs_q.delete();
        s = 0;
        foreach (fq[i]) begin
            p = fq[i].presc;
            n = fq[i].par_en ? 11 : 10;
            start_of.push_back(s);
            push_level(1'b0, p);
            for (int b = 0; b < 8; b++) push_level(fq[i].data[b], p);
            if (fq[i].par_en) begin
                pbit = (^fq[i].data) ^ fq[i].par_typ ^ fq[i].flip;
                push_level(pbit, p);
            end
            push_level(fq[i].stop, p);
            push_level(1'b1, fq[i].gap);
            if (fq[i].par_en && fq[i].flip) exp_q.push_back('{s + (n - 1) * p, K_PE, model_pdata});
            if (!fq[i].stop) begin
                exp_q.push_back('{s + n * p, K_SE, model_pdata});
            end else if (!(fq[i].par_en && fq[i].flip)) begin
                exp_q.push_back('{s + n * p, K_DV, fq[i].data});
                model_pdata = fq[i].data;
            end
            s = s + n * p + fq[i].gap;
        end
        fi    = 0;
        total = line_q.size() + 8;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            if (data_valid) obs_q.push_back('{k, K_DV, p_data});
            if (par_err)    obs_q.push_back('{k, K_PE, p_data});
            if (stp_err)    obs_q.push_back('{k, K_SE, p_data});
            if (fi < start_of.size() && k == start_of[fi]) begin
                prescale = PRESC_W'(fq[fi].presc);
                par_en   = fq[fi].par_en;
                par_typ  = fq[fi].par_typ;
                fi++;
            end else begin
                // Config must be ignored mid-frame, so keep it moving.
                prescale = PRESC_W'(pick_presc());
                par_en   = 1'($urandom);
                par_typ  = 1'($urandom);
            end
            rx_in = (k < line_q.size()) ? line_q[k] : 1'b1;
        end
        check("busy_after_seq", busy, 1'b0);
    endtask

    task automatic compare_model(input string tag);
        int m;
        check($sformatf("%s_event_count", tag), obs_q.size(), exp_q.size());
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_ev%0d_cycle", tag, i), obs_q[i].cyc, exp_q[i].cyc);
            check($sformatf("%s_ev%0d_kind", tag, i), obs_q[i].kind, exp_q[i].kind);
            check($sformatf("%s_ev%0d_pdata", tag, i), obs_q[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        int         pulses;
        logic [9:0] a5_bits;
        frame_t     f;

        // Each row assumes P_DATA left by the rows above it.
        vt[0] = '{'{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 4},  K_DV, 80,  8'hA5};
        vt[1] = '{'{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 4},  K_DV, 176, 8'h3C};
        vt[2] = '{'{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 4},  K_PE, 160, 8'h3C};
        vt[3] = '{'{32, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 40}, K_SE, 352, 8'h3C};
        vt[4] = '{'{8,  1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 4},  K_DV, 88,  8'h5A};
        vt[5] = '{'{32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 40}, K_SE, 320, 8'h5A};

        rst      = 1'b1;
        rx_in    = 1'b1;
        prescale = PRESC_W'(8);
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_p_data", p_data, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_pulses", {data_valid, par_err, stp_err}, 3'b000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            fq.delete();
            fq.push_back(vt[i].f);
            play();
            check($sformatf("vec%0d_event_count", i), obs_q.size(), 1);
            if (obs_q.size() > 0) begin
                check($sformatf("vec%0d_kind", i), obs_q[0].kind, vt[i].exp_kind);
                check($sformatf("vec%0d_cycle", i), obs_q[0].cyc, vt[i].exp_cyc);
            end
            check($sformatf("vec%0d_p_data", i), p_data, vt[i].exp_pdata);
        end

        // Start glitch: three low cycles, then back to idle level.
        pulses = 0;
        @(negedge clk);
        prescale = PRESC_W'(8);
        par_en   = 1'b0;
        rx_in    = 1'b0;
        for (int k = 1; k < 24; k++) begin
            @(negedge clk);
            if (data_valid || par_err || stp_err) pulses++;
            if (k == 7) check("glitch_busy_k7", busy, 1'b1);
            if (k == 8) check("glitch_idle_k8", busy, 1'b0);
            rx_in = (k < 3) ? 1'b0 : 1'b1;
        end
        check("glitch_pulses", pulses, 0);
        check("glitch_p_data_hold", p_data, 8'h5A);

        // Back-to-back frames with no idle cycle between them.
        fq.delete();
        fq.push_back('{8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 0});
        fq.push_back('{8, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1, 4});
        play();
        check("b2b_event_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("b2b_first_cycle", obs_q[0].cyc, 80);
            check("b2b_first_data", obs_q[0].data, 8'h55);
            check("b2b_second_cycle", obs_q[1].cyc, 160);
            check("b2b_second_data", obs_q[1].data, 8'hF0);
            check("b2b_second_kind", obs_q[1].kind, K_DV);
        end

        // Reset in the middle of a frame.
        a5_bits = {1'b1, 8'hA5, 1'b0};
        pulses  = 0;
        @(negedge clk);
        prescale = PRESC_W'(8);
        par_en   = 1'b0;
        rx_in    = 1'b0;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (data_valid || par_err || stp_err) pulses++;
            rx_in = a5_bits[k / 8];
        end
        @(negedge clk);
        rst   = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        check("midrst_p_data", p_data, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_pulses", {data_valid, par_err, stp_err}, 3'b000);
        rst         = 1'b0;
        model_pdata = 8'h00;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (data_valid || par_err || stp_err) pulses++;
        end
        check("midrst_no_pulses", pulses, 0);
        fq.delete();
        fq.push_back('{8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 4});
        play();
        check("midrst_next_count", obs_q.size(), 1);
        if (obs_q.size() > 0) check("midrst_next_cycle", obs_q[0].cyc, 80);
        check("midrst_next_p_data", p_data, 8'h81);

        // Random frame stream against the timing model.
        fq.delete();
        for (int i = 0; i < 25; i++) begin
            f.presc   = pick_presc();
            f.par_en  = 1'($urandom);
            f.par_typ = 1'($urandom);
            f.data    = 8'($urandom);
            f.flip    = f.par_en && ($urandom_range(0, 3) == 0);
            f.stop    = ($urandom_range(0, 4) != 0);
            // A zero stop bit re-triggers a start; give that phantom bit time to die out.
            f.gap     = f.stop ? $urandom_range(0, 5) : 40 + $urandom_range(0, 7);
            fq.push_back(f);
        end
        play();
        compare_model("rand");
        check("rand_final_p_data", p_data, model_pdata);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload bits per frame.
REQ-002 The block SHALL have parameter PRESC_W, default 6, meaning width of the prescale input.
REQ-003 CLK  input  1  sole clock; all logic rises on posedge CLK.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 RX_IN  input  1  serial line, already synchronous to CLK; idle level 1.
REQ-006 Prescale  input  PRESC_W  CLK cycles per bit; legal values 8, 16, 32.
REQ-007 PAR_EN  input  1  1 = frame carries a parity bit.
REQ-008 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 P_DATA  output  DATA_W  last good received byte, LSB = first data bit.
REQ-010 data_valid  output  1  one-cycle pulse; P_DATA holds a new error-free byte.
REQ-011 par_err  output  1  one-cycle pulse; parity mismatch in the current frame.
REQ-012 stp_err  output  1  one-cycle pulse; stop bit sampled as 0.
REQ-013 busy  output  1  1 while any state other than IDLE is active.

Function
REQ-014 Frame format SHALL be: start(0), DATA_W data bits LSB first, optional parity, one stop(1).
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 Prescale, PAR_EN and PAR_TYP SHALL be captured in IDLE on start detection and held for the whole frame.
REQ-017 In IDLE, RX_IN==0 SHALL move the FSM to START; the detection cycle is edge_cnt 0 of the start bit.
REQ-018 edge_cnt SHALL count 0..Prescale-1 per bit and wrap to 0; bit_cnt SHALL advance on each wrap.
REQ-019 Each bit value SHALL be the majority vote of RX_IN at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
REQ-020 START: if the voted start bit is 1 (glitch), the FSM SHALL return to IDLE at the bit end, with no output pulse.
REQ-021 START to DATA, DATA to PARITY (PAR_EN=1) or STOP (PAR_EN=0), and PARITY to STOP SHALL occur at the edge_cnt wrap.
REQ-022 DATA: voted bits SHALL shift into an internal register LSB first; leave DATA after bit_cnt reaches DATA_W.
REQ-023 Parity SHALL be checked at the end of the parity bit: expected = XOR(data) for even, ~XOR(data) for odd; par_err SHALL pulse the next cycle on mismatch.
REQ-024 At the end of the stop bit, stp_err SHALL pulse the next cycle if the voted stop bit is 0.
REQ-025 With no parity error and no stop error in the frame, P_DATA SHALL load the byte and data_valid SHALL pulse in the same cycle.
REQ-026 Latency: with the detection cycle as cycle 0 and N = 10 (+1 if PAR_EN) bits, data_valid/stp_err SHALL be high in cycle N*Prescale.
REQ-027 After STOP the FSM SHALL enter START directly if RX_IN==0 in that cycle, else IDLE (back-to-back frames).
REQ-028 P_DATA SHALL hold its value until the next good frame; errored frames SHALL NOT update it.
REQ-029 Illegal Prescale values SHALL yield unspecified data but the FSM SHALL still return to IDLE.

Reset
REQ-030 RST SHALL force IDLE, clear the counters, and set P_DATA=0, data_valid=0, par_err=0, stp_err=0 and busy=0 on the next edge.
REQ-031 RST asserted mid-frame SHALL abort the frame without any output pulse; reception SHALL resume on the next falling edge after release.

Structure
REQ-032 Package uart_rx_pkg SHALL hold the state enum and the legal prescale constants (8/16/32).
REQ-033 One sub-module, uart_rx_sampler (3-tap majority vote at the mid-bit edges), SHALL be instantiated; counters, FSM and checkers stay in uart_rx.

Verification
REQ-034 Prescale=8, PAR_EN=0, send 0xA5 -> P_DATA=0xA5, data_valid pulse at cycle 80, no errors.
REQ-035 Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> data_valid at cycle 176; same byte with parity 1 -> par_err pulse and P_DATA unchanged.
REQ-036 Prescale=32, PAR_EN=1, PAR_TYP=1, send 0x00 with stop=0 -> stp_err pulse at cycle 352, no data_valid.
REQ-037 Prescale=8, RX_IN low for 3 cycles then high -> FSM back to IDLE by cycle 8, no pulses, busy low afterwards.
REQ-038 Prescale=8, frames 0x55 then 0xF0 back-to-back with no idle -> two data_valid pulses at cycles 80 and 160.
REQ-039 RST pulse at cycle 40 of a frame -> outputs zero, then a following 0x81 frame -> P_DATA=0x81.
